rtype_exec_unit: RTL

Multi-cycle R-type execution controller that sits directly upstream of the ALU. Accepts a 32-bit MIPS R-type instruction word over a valid/ready handshake, reads operands from an internal 32×32 register file, and decodes `funct` into the 4-bit ALU control code. It drives the external ALU's `ALUcontrol`/`A`/`B` inputs, captures `ALUout`/`zero`, and writes the result back to `rd`.

---
 rtl/rtype_pkg.sv | 61 ++++++
 rtl/rtype_exec_unit_regfile.sv | 38 +++
 rtl/rtype_exec_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/rtype_pkg.sv
// Shared definitions for the R-type execution controller: ALU control codes,
// funct encodings, FSM state encoding and the instruction decoder.
package rtype_pkg;

  localparam int NREGS = 32;

  // ALU control codes driven onto ALUcontrol
  localparam logic [3:0] ALU_ADD = 4'b1000;
  localparam logic [3:0] ALU_SUB = 4'b1001;
  localparam logic [3:0] ALU_AND = 4'b1100;
  localparam logic [3:0] ALU_OR  = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1011;
  localparam logic [3:0] ALU_SRL = 4'b1010;
  localparam logic [3:0] ALU_SRA = 4'b0010;

  // funct field encodings of the supported R-type instructions
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_t;

  typedef struct packed {
    logic       legal;  // opcode is 0 and funct is supported
    logic       shift;  // A operand comes from shamt instead of rs
    logic [3:0] ctrl;   // ALU control code, 0000 when illegal
  } dec_t;

  // Map an instruction word onto ALU control; anything unknown is illegal.
  function automatic dec_t decode_instr(input logic [31:0] instr);
    dec_t d;
    d = '0;
    if (instr[31:26] == 6'd0) begin
      d.legal = 1'b1;
      unique case (instr[5:0])
        FN_ADD:  d.ctrl = ALU_ADD;
        FN_SUB:  d.ctrl = ALU_SUB;
        FN_AND:  d.ctrl = ALU_AND;
        FN_OR:   d.ctrl = ALU_OR;
        FN_SLT:  d.ctrl = ALU_SLT;
        FN_SLL:  begin d.ctrl = ALU_SLL; d.shift = 1'b1; end
        FN_SRL:  begin d.ctrl = ALU_SRL; d.shift = 1'b1; end
        FN_SRA:  begin d.ctrl = ALU_SRA; d.shift = 1'b1; end
        default: d.legal = 1'b0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/rtype_exec_unit_regfile.sv
// 32x32 register file: two operand read ports, one debug read port, one write
// port. Register 0 reads as zero and ignores writes.
module regfile_2r1w
  import rtype_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  output logic [31:0] rdata_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_b,
  input  logic [4:0]  raddr_d,
  output logic [31:0] rdata_d
);

  logic [31:0] regs [NREGS];

  // Register storage with async clear; writes to r0 are dropped.
  // NOTE: the whole array sits in the reset branch on purpose -- reset must
  // clear every register, so this maps to flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : regs[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : regs[raddr_b];
  assign rdata_d = (raddr_d == 5'd0) ? 32'd0 : regs[raddr_d];

endmodule

// File: rtl/rtype_exec_unit.sv
// Multi-cycle R-type execution controller. Accepts one instruction per four
// cycles, reads operands, drives the external ALU and writes the result back.
module rtype_exec_unit
  import rtype_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  output logic        done,
  output logic        err,
  output logic [31:0] result,
  output logic        zero_flag,
  input  logic        dbg_we,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata
);

  state_t      state_q, state_d;
  logic [31:0] instr_q;
  logic        legal_q;
  logic [3:0]  alu_ctrl_q;
  logic [31:0] alu_a_q, alu_b_q;
  logic [31:0] cap_q;
  logic        cap_zero_q;
  logic [31:0] result_q;
  logic        zero_q;
  logic        done_q, err_q;

  dec_t        dec;
  logic [31:0] rs_val, rt_val;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  assign dec = decode_instr(instr_q);

  // The WB write and the debug write live in disjoint states, so one port serves both.
  assign rf_we    = ((state_q == ST_WB) && legal_q) || ((state_q == ST_IDLE) && dbg_we);
  assign rf_waddr = (state_q == ST_WB) ? instr_q[15:11] : dbg_addr;
  assign rf_wdata = (state_q == ST_WB) ? cap_q : dbg_wdata;

  regfile_2r1w u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (instr_q[25:21]),
    .rdata_a (rs_val),
    .raddr_b (instr_q[20:16]),
    .rdata_b (rt_val),
    .raddr_d (dbg_addr),
    .rdata_d (dbg_rdata)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fixed four-cycle walk once an instruction is accepted.
  // NOTE: state_d is defaulted before the case so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (in_valid) state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC:   state_d = ST_WB;
      ST_WB:     state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath: latch instruction, load ALU operands, capture ALU result, retire.
  // NOTE: non-blocking assignments keep every register sampling pre-edge values,
  // so the order of statements below does not matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= '0;
      legal_q    <= 1'b0;
      alu_ctrl_q <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      cap_q      <= '0;
      cap_zero_q <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) instr_q <= in_instr;
        end
        ST_DECODE: begin
          legal_q    <= dec.legal;
          alu_ctrl_q <= dec.ctrl;
          alu_a_q    <= dec.shift ? {27'd0, instr_q[10:6]} : rs_val;
          alu_b_q    <= rt_val;
        end
        ST_EXEC: begin
          cap_q      <= alu_out;
          cap_zero_q <= alu_zero;
        end
        ST_WB: begin
          done_q <= 1'b1;
          err_q  <= ~legal_q;
          if (legal_q) begin
            result_q <= cap_q;
            zero_q   <= cap_zero_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign alu_ctrl  = alu_ctrl_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign done      = done_q;
  assign err       = err_q;
  assign result    = result_q;
  assign zero_flag = zero_q;

endmodule
